instruction_prefetch_buffer: RTL and testbench

Decoupled fetch front end that sits directly upstream of the IF/ID pipeline register, replacing the bare PC → ROM path. It keeps its own fetch PC and reads one 32-bit word per cycle from the instruction ROM. Fetched `{pc, instruction}` pairs are queued in a small FIFO and presented to IF/ID. The hazard unit's `load_enable` pops the FIFO, and a redirect from the branch/jump logic flushes it.

---
 rtl/instruction_prefetch_buffer.sv | 124 ++++++++++++
 tb/tb_instruction_prefetch_buffer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_prefetch_buffer.sv
// ---------------------------------------------------------------------------
// instruction_prefetch_buffer
//
// Decoupled fetch front end feeding the IF/ID register. Keeps its own fetch
// PC, reads one ROM word per cycle and queues {pc, instruction} pairs in a
// small circular FIFO. The hazard unit's load_enable (deq_en) pops the head,
// and a branch/jump redirect (flush) empties the queue and restarts fetch.
//
// Optional feature macro: PREFETCH_BYPASS_EN
//   When defined, an empty queue presents the word being fetched this cycle
//   straight from rom_data, cutting post-flush latency to one cycle.
//   When undefined, outputs come only from registered queue state.
// ---------------------------------------------------------------------------
module instruction_prefetch_buffer #(
   parameter int          DEPTH    = 4,
   parameter int          ROM_AW   = 9,
   parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
   input  logic              clk,
   input  logic              reset,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [31:0]       rom_data,
   input  logic              flush,
   input  logic [31:0]       flush_target,
   input  logic              deq_en,
   output logic              out_valid,
   output logic [31:0]       out_instruction,
   output logic [31:0]       out_pc,
   output logic [31:0]       out_pc_plus4
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

   // Fetch state and queue bookkeeping
   logic [31:0]      fetch_pc;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;

   // Queue storage: one {pc, instruction} pair per entry
   logic [31:0] pc_mem    [DEPTH];
   logic [31:0] instr_mem [DEPTH];

   // Control decode
   logic head_valid;
   logic bypass_active;
   logic push;
   logic pop;

   // The ROM sees only the low address bits; fetch_pc keeps all 32 bits.
   assign rom_addr = fetch_pc[ROM_AW-1:0];

   // Derive head validity, bypass condition and the push/pop strobes.
   always_comb begin
      // NOTE: every signal written here is assigned up front, so no path can
      // leave one unassigned and infer a latch.
      head_valid    = (count != '0);
      bypass_active = 1'b0;
      out_valid     = 1'b0;
      pop           = 1'b0;
      push          = 1'b0;
`ifdef PREFETCH_BYPASS_EN
      bypass_active = (count == '0) & ~reset & ~flush;
`endif
      out_valid = ~reset & (head_valid | bypass_active);
      pop       = deq_en & out_valid & ~flush;
      push      = ~flush & ((count < FULL_COUNT) | pop);
   end

   // Select what IF/ID sees: the bypassed ROM word, the queue head, or a NOP.
   always_comb begin
      out_instruction = NOP_WORD;
      out_pc          = 32'h0;
      out_pc_plus4    = 32'h0;
      if (bypass_active) begin
         out_instruction = rom_data;
         out_pc          = fetch_pc;
         out_pc_plus4    = fetch_pc + 32'd4;
      end else if (out_valid) begin
         out_instruction = instr_mem[rd_ptr];
         out_pc          = pc_mem[rd_ptr];
         out_pc_plus4    = pc_mem[rd_ptr] + 32'd4;
      end
   end

   // Advance fetch PC, pointers and occupancy; reset dominates flush.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values of the others, independent of statement order.
      if (reset) begin
         fetch_pc <= 32'h0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else if (flush) begin
         fetch_pc <= flush_target;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         if (push) begin
            wr_ptr   <= wr_ptr + PTR_W'(1);
            fetch_pc <= fetch_pc + 32'd4;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Capture the fetched pair into the slot at wr_ptr.
   always_ff @(posedge clk) begin
      // NOTE: the storage array has no reset; count gates every read, so stale
      // contents are never presented and the array can map onto plain RAM.
      if (push) begin
         pc_mem[wr_ptr]    <= fetch_pc;
         instr_mem[wr_ptr] <= rom_data;
      end
   end

endmodule

// File: tb/tb_instruction_prefetch_buffer.sv
// ---------------------------------------------------------------------------
// tb_instruction_prefetch_buffer
//
// Table-driven directed vectors for instruction_prefetch_buffer. Each row
// gives one cycle's inputs and the outputs expected in that cycle, for both
// the default build and the PREFETCH_BYPASS_EN build. A ROM model returns a
// recognisable word derived from its address. A few hand-written sequences
// follow for flush latency and back-to-back streaming.
// ---------------------------------------------------------------------------
module tb_instruction_prefetch_buffer;

   localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef PREFETCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [8:0]  rom_addr;
   logic [31:0] rom_data;
   logic        flush;
   logic [31:0] flush_target;
   logic        deq_en;
   logic        out_valid;
   logic [31:0] out_instruction;
   logic [31:0] out_pc;
   logic [31:0] out_pc_plus4;

   always #5 clk = ~clk;

   instruction_prefetch_buffer #(
      .DEPTH    (4),
      .ROM_AW   (9),
      .NOP_WORD (NOP)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .rom_addr        (rom_addr),
      .rom_data        (rom_data),
      .flush           (flush),
      .flush_target    (flush_target),
      .deq_en          (deq_en),
      .out_valid       (out_valid),
      .out_instruction (out_instruction),
      .out_pc          (out_pc),
      .out_pc_plus4    (out_pc_plus4)
   );

   // ROM model: each word encodes its own byte address.
   function automatic logic [31:0] rom_word(input logic [8:0] a);
      return {16'hC0DE, 7'd0, a};
   endfunction

   assign rom_data = rom_word(rom_addr);

   // One row = one cycle: inputs, default-build and bypass-build expectations.
   typedef struct {
      logic        rst;
      logic        fl;
      logic [31:0] tgt;
      logic        deq;
      logic        v;
      logic [31:0] pc;
      logic        bv;
      logic [31:0] bpc;
      logic [8:0]  rom;
   } vec_t;

   vec_t vecs[$];

   int n_vec = 0;
   int n_bad = 0;

   function automatic vec_t mk(input logic rst, input logic fl, input logic [31:0] tgt,
                               input logic deq, input logic v, input logic [31:0] pc,
                               input logic bv, input logic [31:0] bpc, input logic [8:0] rom);
      vec_t t;
      t.rst = rst; t.fl = fl; t.tgt = tgt; t.deq = deq;
      t.v = v; t.pc = pc; t.bv = bv; t.bpc = bpc; t.rom = rom;
      return t;
   endfunction

   // Expected {valid, instruction, pc, pc+4, rom_addr} for a given head.
   function automatic logic [105:0] pack_exp(input logic v, input logic [31:0] pc,
                                             input logic [8:0] rom);
      logic [8:0] pa;
      pa = pc[8:0];
      return {v, (v ? rom_word(pa) : NOP), (v ? pc : 32'h0), (v ? pc + 32'd4 : 32'h0), rom};
   endfunction

   task automatic check(input string name, input logic [105:0] act, input logic [105:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t t);
      reset        = t.rst;
      flush        = t.fl;
      flush_target = t.tgt;
      deq_en       = t.deq;
      @(negedge clk);
      check($sformatf("vec%0d", idx),
            {out_valid, out_instruction, out_pc, out_pc_plus4, rom_addr},
            BYP ? pack_exp(t.bv, t.bpc, t.rom) : pack_exp(t.v, t.pc, t.rom));
      @(posedge clk);
      #1;
   endtask

   int lat;

   initial begin
      //            rst fl tgt       deq  v  pc        bv bpc       rom
      // Reset then free-run
      vecs.push_back(mk(1, 0, 32'h0,   0,  0, 32'h0,   0, 32'h0,   9'h000));
      vecs.push_back(mk(0, 0, 32'h0,   1,  0, 32'h0,   1, 32'h0,   9'h000));
      vecs.push_back(mk(0, 0, 32'h0,   1,  1, 32'h0,   1, 32'h4,   9'h004));
      vecs.push_back(mk(0, 0, 32'h0,   1,  1, 32'h4,   1, 32'h8,   9'h008));
      vecs.push_back(mk(0, 0, 32'h0,   1,  1, 32'h8,   1, 32'hC,   9'h00C));
      vecs.push_back(mk(0, 0, 32'h0,   1,  1, 32'hC,   1, 32'h10,  9'h010));
      // Stall fill, saturate at 4, then release
      vecs.push_back(mk(1, 0, 32'h0,   0,  0, 32'h0,   0, 32'h0,   9'h014));
      vecs.push_back(mk(0, 0, 32'h0,   0,  0, 32'h0,   1, 32'h0,   9'h000));
      vecs.push_back(mk(0, 0, 32'h0,   0,  1, 32'h0,   1, 32'h0,   9'h004));
      vecs.push_back(mk(0, 0, 32'h0,   0,  1, 32'h0,   1, 32'h0,   9'h008));
      vecs.push_back(mk(0, 0, 32'h0,   0,  1, 32'h0,   1, 32'h0,   9'h00C));
      vecs.push_back(mk(0, 0, 32'h0,   0,  1, 32'h0,   1, 32'h0,   9'h010));
      vecs.push_back(mk(0, 0, 32'h0,   0,  1, 32'h0,   1, 32'h0,   9'h010));
      vecs.push_back(mk(0, 0, 32'h0,   1,  1, 32'h0,   1, 32'h0,   9'h010));
      vecs.push_back(mk(0, 0, 32'h0,   1,  1, 32'h4,   1, 32'h4,   9'h014));
      vecs.push_back(mk(0, 0, 32'h0,   1,  1, 32'h8,   1, 32'h8,   9'h018));
      vecs.push_back(mk(0, 0, 32'h0,   1,  1, 32'hC,   1, 32'hC,   9'h01C));
      vecs.push_back(mk(0, 0, 32'h0,   1,  1, 32'h10,  1, 32'h10,  9'h020));
      // Full with a single pop: count stays 4, fetch advances once
      vecs.push_back(mk(1, 0, 32'h0,   0,  0, 32'h0,   0, 32'h0,   9'h024));
      vecs.push_back(mk(0, 0, 32'h0,   0,  0, 32'h0,   1, 32'h0,   9'h000));
      vecs.push_back(mk(0, 0, 32'h0,   0,  1, 32'h0,   1, 32'h0,   9'h004));
      vecs.push_back(mk(0, 0, 32'h0,   0,  1, 32'h0,   1, 32'h0,   9'h008));
      vecs.push_back(mk(0, 0, 32'h0,   0,  1, 32'h0,   1, 32'h0,   9'h00C));
      vecs.push_back(mk(0, 0, 32'h0,   1,  1, 32'h0,   1, 32'h0,   9'h010));
      vecs.push_back(mk(0, 0, 32'h0,   0,  1, 32'h4,   1, 32'h4,   9'h014));
      vecs.push_back(mk(0, 0, 32'h0,   0,  1, 32'h4,   1, 32'h4,   9'h014));
      // Flush at count 3 with deq_en high, then wrap through 0x1FC
      vecs.push_back(mk(1, 0, 32'h0,   0,  0, 32'h0,   0, 32'h0,   9'h014));
      vecs.push_back(mk(0, 0, 32'h0,   0,  0, 32'h0,   1, 32'h0,   9'h000));
      vecs.push_back(mk(0, 0, 32'h0,   0,  1, 32'h0,   1, 32'h0,   9'h004));
      vecs.push_back(mk(0, 0, 32'h0,   0,  1, 32'h0,   1, 32'h0,   9'h008));
      vecs.push_back(mk(0, 1, 32'h40,  1,  1, 32'h0,   1, 32'h0,   9'h00C));
      vecs.push_back(mk(0, 0, 32'h0,   0,  0, 32'h0,   1, 32'h40,  9'h040));
      vecs.push_back(mk(0, 0, 32'h0,   1,  1, 32'h40,  1, 32'h40,  9'h044));
      vecs.push_back(mk(0, 0, 32'h0,   1,  1, 32'h44,  1, 32'h44,  9'h048));
      vecs.push_back(mk(0, 1, 32'h1FC, 1,  1, 32'h48,  1, 32'h48,  9'h04C));
      vecs.push_back(mk(0, 0, 32'h0,   1,  0, 32'h0,   1, 32'h1FC, 9'h1FC));
      vecs.push_back(mk(0, 0, 32'h0,   1,  1, 32'h1FC, 1, 32'h200, 9'h000));
      vecs.push_back(mk(0, 0, 32'h0,   1,  1, 32'h200, 1, 32'h204, 9'h004));
      // Reset mid-run with flush high: reset wins
      vecs.push_back(mk(0, 0, 32'h0,   0,  1, 32'h204, 1, 32'h208, 9'h008));
      vecs.push_back(mk(1, 1, 32'h80,  1,  0, 32'h0,   0, 32'h0,   9'h00C));
      vecs.push_back(mk(0, 0, 32'h0,   0,  0, 32'h0,   1, 32'h0,   9'h000));
      vecs.push_back(mk(0, 0, 32'h0,   1,  1, 32'h0,   1, 32'h0,   9'h004));

      reset        = 1'b1;
      flush        = 1'b0;
      flush_target = 32'h0;
      deq_en       = 1'b0;
      @(posedge clk);
      #1;

      foreach (vecs[i]) run_vec(i, vecs[i]);

      // Flush latency: target presented two cycles after the flush (one with bypass).
      reset        = 1'b0;
      flush        = 1'b1;
      flush_target = 32'h100;
      deq_en       = 1'b0;
      @(posedge clk);
      #1;
      flush = 1'b0;
      lat   = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (out_valid) begin
            lat = k;
            break;
         end
         @(posedge clk);
         #1;
      end
      check("flush_latency", 106'(lat), BYP ? 106'd1 : 106'd2);
      check("flush_head", {out_valid, out_instruction, out_pc, out_pc_plus4, 9'd0},
            pack_exp(1'b1, 32'h100, 9'd0));

      // Steady streaming: one instruction per cycle, consecutive PCs.
      @(posedge clk);
      #1;
      deq_en = 1'b1;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         check($sformatf("stream%0d", j),
               {out_valid, out_instruction, out_pc, out_pc_plus4, 9'd0},
               pack_exp(1'b1, 32'h100 + 32'(4 * j), 9'd0));
         @(posedge clk);
         #1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
